// File: rtl/wb_pkg.sv
// Shared types for the writeback/retire stage: entry layout and bus fields.
// Bus is {exc, be, dest, result, pc}, MSB first.
package wb_pkg;

  localparam int WB_XLEN   = 32;
  localparam int WB_REG_AW = 5;
  localparam int WB_BE_W   = WB_XLEN / 8;

  localparam int PC_LSB   = 0;
  localparam int PC_W     = WB_XLEN;
  localparam int RES_LSB  = PC_LSB + PC_W;
  localparam int RES_W    = WB_XLEN;
  localparam int DEST_LSB = RES_LSB + RES_W;
  localparam int DEST_W   = WB_REG_AW;
  localparam int BE_LSB   = DEST_LSB + DEST_W;
  localparam int BE_W_F   = WB_BE_W;
  localparam int EXC_BIT  = BE_LSB + BE_W_F;

  function automatic int bus_w(input int xlen, input int reg_aw);
    return 1 + xlen / 8 + reg_aw + 2 * xlen;
  endfunction

  localparam int WB_BUS_W = bus_w(WB_XLEN, WB_REG_AW);

  typedef struct packed {
    logic                 exc;
    logic [WB_BE_W-1:0]   be;
    logic [WB_REG_AW-1:0] dest;
    logic [WB_XLEN-1:0]   result;
    logic [WB_XLEN-1:0]   pc;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_match.sv
// Youngest-match forwarding lookup over the retire buffer.
// Ports: ents/head/count/vld (buffer view), q_addr in; hit/stall/data out.
module wb_fwd_match
  import wb_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
)(
  input  wb_entry_t            ents [DEPTH],
  input  logic [DEPTH-1:0]     vld,
  input  logic [PW-1:0]        head,
  input  logic [CW-1:0]        count,
  input  logic [WB_REG_AW-1:0] q_addr,
  output logic                 hit,
  output logic                 stall,
  output logic [WB_XLEN-1:0]   data
);

  logic                 found;
  logic [WB_BE_W-1:0]   fbe;
  logic [WB_XLEN-1:0]   fdata;
  logic [PW-1:0]        idx;

  // Walk oldest to youngest; the last match seen is the youngest.
  always_comb begin
    found = 1'b0;
    fbe   = '0;
    fdata = '0;
    idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && vld[idx]
          && !ents[idx].exc && (|ents[idx].be)
          && (q_addr != '0)
          && (ents[idx].dest == q_addr)) begin
        found = 1'b1;
        fbe   = ents[idx].be;
        fdata = ents[idx].result;
      end
    end
  end

  assign hit   = found & (&fbe);
  assign stall = found & ~(&fbe);
  assign data  = hit ? fdata : '0;

endmodule

// File: rtl/wb_retire_buf.sv
// In-order retire FIFO: byte-enable regfile writes, exception flush, fwd.
// Optional trace ports enabled by WB_TRACE_EN (tied to 0 otherwise).
module wb_retire_buf
  import wb_pkg::*;
#(
  parameter int XLEN   = WB_XLEN,
  parameter int REG_AW = WB_REG_AW,
  parameter int DEPTH  = 2,
  localparam int BE_W  = XLEN / 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
)(
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          mem_to_wb_valid,
  input  logic [bus_w(XLEN,REG_AW)-1:0] mem_to_wb_bus,
  output logic                          wb_allowin,
  input  logic                          rf_stall,
  output logic [BE_W-1:0]               rf_we,
  output logic [REG_AW-1:0]             rf_waddr,
  output logic [XLEN-1:0]               rf_wdata,
  output logic                          flush,
  output logic [XLEN-1:0]               flush_pc,
  input  logic [REG_AW-1:0]             q_addr0,
  input  logic [REG_AW-1:0]             q_addr1,
  output logic                          q_hit0,
  output logic                          q_hit1,
  output logic [XLEN-1:0]               q_data0,
  output logic [XLEN-1:0]               q_data1,
  output logic                          q_stall0,
  output logic                          q_stall1,
  output logic [XLEN-1:0]               debug_wb_pc,
  output logic [XLEN-1:0]               debug_wb_rf_wdata,
  output logic [BE_W-1:0]               debug_wb_rf_we,
  output logic [REG_AW-1:0]             debug_wb_rf_wnum
);

  wb_entry_t        ents [DEPTH];
  wb_entry_t        in_e;
  wb_entry_t        hd;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] vld;
  logic             push;
  logic             pop;
  logic             exc_pop;

  always_comb begin
    in_e        = '0;
    in_e.exc    = mem_to_wb_bus[EXC_BIT];
    in_e.be     = mem_to_wb_bus[BE_LSB +: BE_W_F];
    in_e.dest   = mem_to_wb_bus[DEST_LSB +: DEST_W];
    in_e.result = mem_to_wb_bus[RES_LSB +: RES_W];
    in_e.pc     = mem_to_wb_bus[PC_LSB +: PC_W];
  end

  assign hd      = ents[head];
  assign pop     = (count != '0) & ~rf_stall;
  assign exc_pop = pop & hd.exc;

  // A full buffer still accepts when the head leaves this cycle.
  assign wb_allowin = (count < CW'(DEPTH)) | pop;
  assign push       = mem_to_wb_valid & wb_allowin;

  assign rf_we    = (pop & ~hd.exc) ? hd.be : '0;
  assign rf_waddr = hd.dest;
  assign rf_wdata = hd.result;
  assign flush    = exc_pop;
  assign flush_pc = exc_pop ? hd.pc : '0;

  // Slot j is live when its age offset from head is below count.
  always_comb begin
    vld = '0;
    for (int j = 0; j < DEPTH; j++) begin
      vld[j] = CW'(PW'(j) - head) < count;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        ents[j] <= '0;
      end
    end else if (exc_pop) begin
      // Exception retire drops everything, including a same-cycle push.
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        ents[tail] <= in_e;
        tail       <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd0 (
    .ents   (ents),
    .vld    (vld),
    .head   (head),
    .count  (count),
    .q_addr (q_addr0),
    .hit    (q_hit0),
    .stall  (q_stall0),
    .data   (q_data0)
  );

  wb_fwd_match #(.DEPTH(DEPTH)) u_fwd1 (
    .ents   (ents),
    .vld    (vld),
    .head   (head),
    .count  (count),
    .q_addr (q_addr1),
    .hit    (q_hit1),
    .stall  (q_stall1),
    .data   (q_data1)
  );

`ifdef WB_TRACE_EN
  assign debug_wb_rf_we    = rf_we;
  assign debug_wb_rf_wnum  = (|rf_we) ? hd.dest : '0;
  assign debug_wb_rf_wdata = (|rf_we) ? hd.result : '0;
  assign debug_wb_pc       = (|rf_we) ? hd.pc : '0;
`else
  assign debug_wb_rf_we    = '0;
  assign debug_wb_rf_wnum  = '0;
  assign debug_wb_rf_wdata = '0;
  assign debug_wb_pc       = '0;
`endif

endmodule

// File: tb/tb_wb_retire_buf.sv
// Directed bench for wb_retire_buf (DEPTH=2, XLEN=32).
// Inputs driven on negedge, outputs checked 1ns later.
module tb_wb_retire_buf;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_to_wb_valid;
  logic [73:0] mem_to_wb_bus;
  logic        wb_allowin;
  logic        rf_stall;
  logic [3:0]  rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        flush;
  logic [31:0] flush_pc;
  logic [4:0]  q_addr0, q_addr1;
  logic        q_hit0, q_hit1;
  logic [31:0] q_data0, q_data1;
  logic        q_stall0, q_stall1;
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  wb_retire_buf #(.XLEN(32), .REG_AW(5), .DEPTH(2)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .wb_allowin        (wb_allowin),
    .rf_stall          (rf_stall),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .flush             (flush),
    .flush_pc          (flush_pc),
    .q_addr0           (q_addr0),
    .q_addr1           (q_addr1),
    .q_hit0            (q_hit0),
    .q_hit1            (q_hit1),
    .q_data0           (q_data0),
    .q_data1           (q_data1),
    .q_stall0          (q_stall0),
    .q_stall1          (q_stall1),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wdata (debug_wb_rf_wdata),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum)
  );

  function automatic logic [73:0] mk(input logic e, input logic [3:0] be,
                                     input logic [4:0] d,
                                     input logic [31:0] r,
                                     input logic [31:0] pc);
    return {e, be, d, r, pc};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    resetn          = 1'b0;
    mem_to_wb_valid = 1'b0;
    mem_to_wb_bus   = '0;
    rf_stall        = 1'b0;
    q_addr0         = '0;
    q_addr1         = '0;
    #2;
    chk("rst_count", 64'(dut.count), 64'd0);
    chk("rst_allowin", 64'(wb_allowin), 64'd1);
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_waddr", 64'(rf_waddr), 64'd0);
    chk("rst_hit0", 64'(q_hit0), 64'd0);
    nxt();
    nxt();
    resetn = 1'b1;

    // single entry
    nxt();
    mem_to_wb_valid = 1'b1;
    mem_to_wb_bus   = mk(0, 4'hF, 5, 32'h1234_5678, 32'h100);
    q_addr0         = 5;
    settle();
    chk("t1_nobypass_we", 64'(rf_we), 64'd0);
    chk("t1_nobypass_hit", 64'(q_hit0), 64'd0);
    nxt();
    mem_to_wb_valid = 1'b0;
    settle();
    chk("t1_we", 64'(rf_we), 64'hF);
    chk("t1_waddr", 64'(rf_waddr), 64'd5);
    chk("t1_wdata", 64'(rf_wdata), 64'h1234_5678);
    chk("t1_hit0", 64'(q_hit0), 64'd1);
    chk("t1_data0", 64'(q_data0), 64'h1234_5678);
    chk("t1_dbg_we", 64'(debug_wb_rf_we), 64'd0);
    nxt();
    settle();
    chk("t1_drained", 64'(dut.count), 64'd0);
    chk("t1_we_idle", 64'(rf_we), 64'd0);

    // fill under stall, then drain in order
    rf_stall        = 1'b1;
    mem_to_wb_valid = 1'b1;
    mem_to_wb_bus   = mk(0, 4'hF, 1, 32'h11, 32'h200);
    nxt();
    mem_to_wb_bus = mk(0, 4'hF, 2, 32'h22, 32'h204);
    nxt();
    mem_to_wb_bus = mk(0, 4'hF, 3, 32'h33, 32'h208);
    settle();
    chk("t2_full_allowin", 64'(wb_allowin), 64'd0);
    chk("t2_stall_we", 64'(rf_we), 64'd0);
    nxt();
    chk("t2_full_count", 64'(dut.count), 64'd2);
    rf_stall = 1'b0;
    settle();
    chk("t2_popfull_allowin", 64'(wb_allowin), 64'd1);
    chk("t2_w1_we", 64'(rf_we), 64'hF);
    chk("t2_w1_addr", 64'(rf_waddr), 64'd1);
    nxt();
    mem_to_wb_valid = 1'b0;
    settle();
    chk("t2_count_held", 64'(dut.count), 64'd2);
    chk("t2_w2_addr", 64'(rf_waddr), 64'd2);
    chk("t2_w2_data", 64'(rf_wdata), 64'h22);
    nxt();
    settle();
    chk("t2_w3_addr", 64'(rf_waddr), 64'd3);
    chk("t2_w3_data", 64'(rf_wdata), 64'h33);
    nxt();
    settle();
    chk("t2_empty", 64'(dut.count), 64'd0);

    // youngest match
    rf_stall        = 1'b1;
    mem_to_wb_valid = 1'b1;
    mem_to_wb_bus   = mk(0, 4'hF, 7, 32'hA, 32'h300);
    q_addr1         = 7;
    nxt();
    mem_to_wb_bus = mk(0, 4'hF, 7, 32'hB, 32'h304);
    nxt();
    mem_to_wb_valid = 1'b0;
    settle();
    chk("t3_hit1", 64'(q_hit1), 64'd1);
    chk("t3_data1", 64'(q_data1), 64'hB);
    chk("t3_stall1", 64'(q_stall1), 64'd0);
    rf_stall = 1'b0;
    nxt();
    nxt();
    settle();
    chk("t3_drained", 64'(dut.count), 64'd0);
    rf_stall        = 1'b1;
    mem_to_wb_valid = 1'b1;
    mem_to_wb_bus   = mk(0, 4'hF, 7, 32'hA, 32'h310);
    nxt();
    mem_to_wb_bus = mk(0, 4'h3, 7, 32'hC, 32'h314);
    nxt();
    mem_to_wb_valid = 1'b0;
    settle();
    chk("t3p_stall1", 64'(q_stall1), 64'd1);
    chk("t3p_hit1", 64'(q_hit1), 64'd0);
    chk("t3p_data1", 64'(q_data1), 64'd0);
    rf_stall = 1'b0;
    nxt();
    nxt();

    // exception retire
    rf_stall        = 1'b1;
    mem_to_wb_valid = 1'b1;
    mem_to_wb_bus   = mk(1, 4'hF, 9, 32'h99, 32'hBFC0_0380);
    q_addr0         = 9;
    nxt();
    mem_to_wb_bus = mk(0, 4'hF, 10, 32'h1010, 32'h400);
    nxt();
    settle();
    chk("t4_exc_nofwd", 64'(q_hit0), 64'd0);
    mem_to_wb_bus = mk(0, 4'hF, 11, 32'h1111, 32'h404);
    rf_stall      = 1'b0;
    settle();
    chk("t4_we", 64'(rf_we), 64'd0);
    chk("t4_flush", 64'(flush), 64'd1);
    chk("t4_flush_pc", 64'(flush_pc), 64'hBFC0_0380);
    nxt();
    mem_to_wb_valid = 1'b0;
    settle();
    chk("t4_flush_once", 64'(flush), 64'd0);
    chk("t4_count0", 64'(dut.count), 64'd0);
    chk("t4_we_after", 64'(rf_we), 64'd0);

    // reset mid-stall
    rf_stall        = 1'b1;
    mem_to_wb_valid = 1'b1;
    mem_to_wb_bus   = mk(0, 4'hF, 12, 32'hC0, 32'h500);
    nxt();
    mem_to_wb_bus = mk(1, 4'hF, 13, 32'hD0, 32'h504);
    nxt();
    mem_to_wb_valid = 1'b0;
    settle();
    chk("t5_pre_count", 64'(dut.count), 64'd2);
    resetn   = 1'b0;
    rf_stall = 1'b0;
    settle();
    chk("t5_count", 64'(dut.count), 64'd0);
    chk("t5_we", 64'(rf_we), 64'd0);
    chk("t5_flush", 64'(flush), 64'd0);
    chk("t5_allowin", 64'(wb_allowin), 64'd1);
    nxt();
    resetn = 1'b1;
    nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
